// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction constants, load-controller states, defaults.
package cpu_pkg;

    localparam logic [31:0]  NOP_INSN       = 32'd8;
    localparam int unsigned  WORD_BYTES     = 4;
    localparam int unsigned  IMEM_DEPTH_DEF = 256;

    // Program-load sequencing states
    typedef enum logic [2:0] {
        LDST_IDLE    = 3'd0,
        LDST_LOAD    = 3'd1,
        LDST_DRAIN   = 3'd2,
        LDST_RELEASE = 3'd3,
        LDST_RUN     = 3'd4
    } ldst_e;

endpackage : cpu_pkg

// File: rtl/imem_addr_check.sv
// Combinational host byte-address check: word alignment, memory range, word index.
module imem_addr_check
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF
) (
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          o_aligned_c,
    output logic                          o_in_range_c,
    output logic [$clog2(IMEM_DEPTH)-1:0] o_waddr_c
);

    localparam int unsigned OFF_W = $clog2(WORD_BYTES);
    localparam int unsigned AW    = $clog2(IMEM_DEPTH);

    // Byte offset must be zero; any address bit above the word index means out of range
    assign o_aligned_c  = (i_addr[OFF_W-1:0] == '0);
    assign o_in_range_c = (i_addr[ADDR_W-1:OFF_W+AW] == '0);
    assign o_waddr_c    = i_addr[OFF_W+AW-1:OFF_W];

endmodule : imem_addr_check

// File: rtl/imem_load_ctrl.sv
// Host program-load receiver: writes instruction memory, tracks errors, holds and boots cores.
module imem_load_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned IMEM_DEPTH  = IMEM_DEPTH_DEF,
    parameter int unsigned RELEASE_DLY = 2
) (
    input  logic                            sclk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [ADDR_W-1:0]               addr,
    input  logic [DATA_W-1:0]               instr,
    output logic                            imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0]   imem_waddr,
    output logic [DATA_W-1:0]               imem_wdata,
    output logic                            core_hold,
    output logic                            boot_go,
    output logic                            err_misalign,
    output logic                            err_range,
    output logic [$clog2(IMEM_DEPTH):0]     word_count
);

    localparam int unsigned AW    = $clog2(IMEM_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DLY_W = $clog2(RELEASE_DLY + 1);

    ldst_e              r_state;
    ldst_e              w_state_nxt;
    logic [DLY_W-1:0]   r_dly;
    logic [DLY_W-1:0]   w_dly_nxt;
    logic               w_cap;
    logic               w_start;
    logic               w_hold_nxt;
    logic               w_boot_nxt;

    logic               r_cap_v;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_instr;
    logic               w_aligned;
    logic               w_in_range;
    logic [AW-1:0]      w_waddr;
    logic               w_wr_ok;

    logic               r_we;
    logic [AW-1:0]      r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_core_hold;
    logic               r_boot_go;
    logic               r_err_misalign;
    logic               r_err_range;
    logic [CW-1:0]      r_word_count;

    // Address check runs on the captured word, one cycle ahead of the write strobe
    imem_addr_check #(
        .ADDR_W     (ADDR_W),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_addr_check (
        .i_addr       (r_addr),
        .o_aligned_c  (w_aligned),
        .o_in_range_c (w_in_range),
        .o_waddr_c    (w_waddr)
    );

    assign w_wr_ok = r_cap_v & w_aligned & w_in_range;

    // State and release-delay counter registers
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            r_state <= LDST_IDLE;
            r_dly   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= w_dly_nxt;
        end
    end

    // Next state, word capture, load-start clear and next values of hold/boot
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_cap       = 1'b0;
        w_start     = 1'b0;
        w_hold_nxt  = 1'b1;
        w_boot_nxt  = 1'b0;
        case (r_state)
            LDST_IDLE, LDST_RUN: begin
                if (load) begin
                    w_state_nxt = LDST_LOAD;
                    w_cap       = 1'b1;
                    w_start     = 1'b1;
                end
            end
            LDST_LOAD: begin
                if (load) begin
                    w_cap = 1'b1;
                end else begin
                    w_state_nxt = LDST_DRAIN;
                end
            end
            LDST_DRAIN: begin
                w_state_nxt = LDST_RELEASE;
                w_dly_nxt   = DLY_W'(RELEASE_DLY - 1);
            end
            LDST_RELEASE: begin
                // A resumed load continues the same program: no clear, no boot
                if (load) begin
                    w_state_nxt = LDST_LOAD;
                    w_cap       = 1'b1;
                end else if (r_dly == '0) begin
                    w_state_nxt = LDST_RUN;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            default: begin
                w_state_nxt = LDST_IDLE;
            end
        endcase
        w_hold_nxt = (w_state_nxt != LDST_RUN);
        w_boot_nxt = (w_state_nxt == LDST_RUN) && (r_state != LDST_RUN);
    end

    // Capture stage, write stage, sticky status and registered control outputs
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            r_cap_v        <= 1'b0;
            r_addr         <= '0;
            r_instr        <= '0;
            r_we           <= 1'b0;
            r_waddr        <= '0;
            r_wdata        <= '0;
            r_core_hold    <= 1'b1;
            r_boot_go      <= 1'b0;
            r_err_misalign <= 1'b0;
            r_err_range    <= 1'b0;
            r_word_count   <= '0;
        end else begin
            r_cap_v     <= w_cap;
            r_core_hold <= w_hold_nxt;
            r_boot_go   <= w_boot_nxt;
            r_we        <= w_wr_ok;
            if (w_cap) begin
                r_addr  <= addr;
                r_instr <= instr;
            end
            if (w_wr_ok) begin
                r_waddr <= w_waddr;
                r_wdata <= r_instr;
            end
            if (w_start) begin
                r_err_misalign <= 1'b0;
                r_err_range    <= 1'b0;
                r_word_count   <= '0;
            end else if (r_cap_v) begin
                if (!w_aligned) begin
                    r_err_misalign <= 1'b1;
                end
                if (!w_in_range) begin
                    r_err_range <= 1'b1;
                end
                if (w_wr_ok && (r_word_count != CW'(IMEM_DEPTH))) begin
                    r_word_count <= r_word_count + CW'(1);
                end
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_waddr   = r_waddr;
    assign imem_wdata   = r_wdata;
    assign core_hold    = r_core_hold;
    assign boot_go      = r_boot_go;
    assign err_misalign = r_err_misalign;
    assign err_range    = r_err_range;
    assign word_count   = r_word_count;

endmodule : imem_load_ctrl

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with hand-computed expectations.
module tb_imem_load_ctrl;

    logic        sclk;
    logic        reset;
    logic        load;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        boot_go;
    logic        err_misalign;
    logic        err_range;
    logic [8:0]  word_count;

    int checks;
    int failures;

    imem_load_ctrl #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .IMEM_DEPTH  (256),
        .RELEASE_DLY (2)
    ) dut (
        .sclk         (sclk),
        .reset        (reset),
        .load         (load),
        .addr         (addr),
        .instr        (instr),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .boot_go      (boot_go),
        .err_misalign (err_misalign),
        .err_range    (err_range),
        .word_count   (word_count)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Advance one clock; outputs are observed 1 ns after the rising edge
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic l, input logic [31:0] a, input logic [31:0] d);
        load  = l;
        addr  = a;
        instr = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // Reset held from t0
        repeat (2) step();
        chk("rst_hold",   64'(core_hold),    64'd1);
        chk("rst_we",     64'(imem_we),      64'd0);
        chk("rst_boot",   64'(boot_go),      64'd0);
        chk("rst_emis",   64'(err_misalign), 64'd0);
        chk("rst_erng",   64'(err_range),    64'd0);
        chk("rst_wcnt",   64'(word_count),   64'd0);

        // Out of reset with no load: must stay held, never boot
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_hold", 64'(core_hold), 64'd1);
            chk("idle_boot", 64'(boot_go),   64'd0);
        end

        // First program: three valid words
        drive(1'b1, 32'h0, 32'd8);
        step();                                   // IDLE -> LOAD, word 0 captured
        chk("l1_hold0",  64'(core_hold),  64'd1);
        chk("l1_we0",    64'(imem_we),    64'd0);
        drive(1'b1, 32'h8, 32'h3400_0014);
        step();
        chk("l1_we_a",   64'(imem_we),    64'd1);
        chk("l1_wa_a",   64'(imem_waddr), 64'd0);
        chk("l1_wd_a",   64'(imem_wdata), 64'd8);
        chk("l1_cnt_a",  64'(word_count), 64'd1);
        drive(1'b1, 32'hC, 32'h3020_0000);
        step();
        chk("l1_we_b",   64'(imem_we),    64'd1);
        chk("l1_wa_b",   64'(imem_waddr), 64'd2);
        chk("l1_wd_b",   64'(imem_wdata), 64'h3400_0014);
        drive(1'b0, 32'h0, 32'h0);
        step();                                   // load=0 sampled -> DRAIN, last write lands here
        chk("l1_we_c",   64'(imem_we),    64'd1);
        chk("l1_wa_c",   64'(imem_waddr), 64'd3);
        chk("l1_wd_c",   64'(imem_wdata), 64'h3020_0000);
        chk("l1_cnt_c",  64'(word_count), 64'd3);
        step();                                   // RELEASE
        chk("l1_we_off", 64'(imem_we),    64'd0);
        chk("l1_hold_r1",64'(core_hold),  64'd1);
        step();
        chk("l1_hold_r2",64'(core_hold),  64'd1);
        chk("l1_boot_r2",64'(boot_go),    64'd0);
        step();                                   // 1 + RELEASE_DLY after load fell -> RUN
        chk("l1_hold_run",64'(core_hold), 64'd0);
        chk("l1_boot_run",64'(boot_go),   64'd1);
        step();
        chk("l1_boot_1cy",64'(boot_go),   64'd0);
        chk("l1_hold_run2",64'(core_hold),64'd0);
        chk("l1_cnt_keep",64'(word_count),64'd3);

        // Second program: misaligned, out of range, top word twice
        drive(1'b1, 32'h6, 32'd8);
        step();                                   // RUN -> LOAD
        chk("l2_hold",   64'(core_hold),  64'd1);
        chk("l2_cnt_clr",64'(word_count), 64'd0);
        drive(1'b1, 32'h400, 32'h11);
        step();                                   // check of 0x6
        chk("l2_mis_we", 64'(imem_we),    64'd0);
        chk("l2_mis_e",  64'(err_misalign),64'd1);
        chk("l2_mis_r",  64'(err_range),  64'd0);
        drive(1'b1, 32'h3FC, 32'hAB);
        step();                                   // check of 0x400
        chk("l2_rng_we", 64'(imem_we),    64'd0);
        chk("l2_rng_e",  64'(err_range),  64'd1);
        chk("l2_rng_cnt",64'(word_count), 64'd0);
        drive(1'b1, 32'h3FC, 32'hCD);
        step();
        chk("l2_top_we", 64'(imem_we),    64'd1);
        chk("l2_top_wa", 64'(imem_waddr), 64'd255);
        chk("l2_top_wd", 64'(imem_wdata), 64'hAB);
        drive(1'b0, 32'h0, 32'h0);
        step();                                   // DRAIN: repeated address, last wins
        chk("l2_rep_we", 64'(imem_we),    64'd1);
        chk("l2_rep_wa", 64'(imem_waddr), 64'd255);
        chk("l2_rep_wd", 64'(imem_wdata), 64'hCD);
        chk("l2_rep_cnt",64'(word_count), 64'd2);
        drive(1'b1, 32'h10, 32'h55);
        step();                                   // RELEASE, load seen at next edge
        chk("l2_rel_we", 64'(imem_we),    64'd0);
        step();                                   // RELEASE -> LOAD, no clear, no boot
        chk("l2_back_hold",64'(core_hold),64'd1);
        chk("l2_back_boot",64'(boot_go),  64'd0);
        chk("l2_back_emis",64'(err_misalign),64'd1);
        chk("l2_back_cnt",64'(word_count),64'd2);
        drive(1'b0, 32'h0, 32'h0);
        step();                                   // DRAIN
        chk("l2_res_we", 64'(imem_we),    64'd1);
        chk("l2_res_wa", 64'(imem_waddr), 64'd4);
        chk("l2_res_cnt",64'(word_count), 64'd3);
        step();
        step();
        chk("l2_rel_hold",64'(core_hold), 64'd1);
        step();
        chk("l2_run_hold",64'(core_hold), 64'd0);
        chk("l2_run_boot",64'(boot_go),   64'd1);
        chk("l2_sticky_m",64'(err_misalign),64'd1);
        chk("l2_sticky_r",64'(err_range), 64'd1);

        // Third program: errors clear at start; reset mid-load drops the write
        drive(1'b1, 32'h14, 32'h1);
        step();
        chk("l3_clr_m",  64'(err_misalign),64'd0);
        chk("l3_clr_r",  64'(err_range),  64'd0);
        chk("l3_clr_cnt",64'(word_count), 64'd0);
        drive(1'b1, 32'h18, 32'h2);
        step();
        chk("l3_we",     64'(imem_we),    64'd1);
        chk("l3_wa",     64'(imem_waddr), 64'd5);
        #2;
        reset = 1'b0;                             // mid-cycle, write for 0x18 pending
        #1;
        chk("ar_we",     64'(imem_we),    64'd0);
        chk("ar_hold",   64'(core_hold),  64'd1);
        chk("ar_cnt",    64'(word_count), 64'd0);
        drive(1'b0, 32'h0, 32'h0);
        step();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_boot", 64'(boot_go),   64'd0);
            chk("post_rst_hold", 64'(core_hold), 64'd1);
            chk("post_rst_we",   64'(imem_we),   64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_load_ctrl
